// File: rtl/pipe_stage_reg.sv
// Parametrised multi-stage pipeline register with stall, flush, per-stage valid,
// occupancy and saturating flush counter. Outputs are the registered last stage.
module pipe_stage_reg #(
    parameter int unsigned DATA_W             = 64,
    parameter int unsigned CTRL_W             = 8,
    parameter int unsigned DEPTH              = 1,
    parameter int unsigned ZERO_DATA_ON_FLUSH = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    input  logic [DATA_W-1:0]            in_data,
    input  logic [CTRL_W-1:0]            in_ctrl,
    input  logic                         stall,
    input  logic                         flush,
    output logic                         out_valid,
    output logic [DATA_W-1:0]            out_data,
    output logic [CTRL_W-1:0]            out_ctrl,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy,
    output logic [15:0]                  flush_count
);

    localparam int unsigned OCC_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0]  r_valid;
    logic [DATA_W-1:0] r_data [DEPTH];
    logic [CTRL_W-1:0] r_ctrl [DEPTH];
    logic [OCC_W-1:0]  r_occ;
    logic [15:0]       r_flush_cnt;

    logic [DEPTH-1:0]  w_valid_d;
    logic [DATA_W-1:0] w_data_d [DEPTH];
    logic [CTRL_W-1:0] w_ctrl_d [DEPTH];
    logic [OCC_W-1:0]  w_occ_d;
    logic [15:0]       w_flush_cnt_d;

    // Flush beats stall; ctrl is forced to 0 for any invalid slot so bubbles stay inert.
    always_comb begin
        w_valid_d     = r_valid;
        w_data_d      = r_data;
        w_ctrl_d      = r_ctrl;
        w_flush_cnt_d = r_flush_cnt;
        if (flush) begin
            w_valid_d = '0;
            for (int k = 0; k < int'(DEPTH); k++) begin
                w_ctrl_d[k] = '0;
                if (ZERO_DATA_ON_FLUSH != 0) begin
                    w_data_d[k] = '0;
                end
            end
            if (r_flush_cnt != 16'hFFFF) begin
                w_flush_cnt_d = r_flush_cnt + 16'd1;
            end
        end else if (!stall) begin
            w_valid_d[0] = in_valid;
            w_data_d[0]  = in_data;
            w_ctrl_d[0]  = in_valid ? in_ctrl : '0;
            for (int k = 1; k < int'(DEPTH); k++) begin
                w_valid_d[k] = r_valid[k-1];
                w_data_d[k]  = r_data[k-1];
                w_ctrl_d[k]  = r_ctrl[k-1];
            end
        end
    end

    always_comb begin
        w_occ_d = '0;
        for (int k = 0; k < int'(DEPTH); k++) begin
            w_occ_d = w_occ_d + OCC_W'(w_valid_d[k]);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_valid     <= '0;
            r_occ       <= '0;
            r_flush_cnt <= '0;
            for (int k = 0; k < int'(DEPTH); k++) begin
                r_data[k] <= '0;
                r_ctrl[k] <= '0;
            end
        end else begin
            r_valid     <= w_valid_d;
            r_occ       <= w_occ_d;
            r_flush_cnt <= w_flush_cnt_d;
            for (int k = 0; k < int'(DEPTH); k++) begin
                r_data[k] <= w_data_d[k];
                r_ctrl[k] <= w_ctrl_d[k];
            end
        end
    end

    assign out_valid   = r_valid[DEPTH-1];
    assign out_data    = r_data[DEPTH-1];
    assign out_ctrl    = r_ctrl[DEPTH-1];
    assign occupancy   = r_occ;
    assign flush_count = r_flush_cnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a DEPTH=3 zeroing instance and a DEPTH=2 data-holding
// instance share inputs and are compared against a queue-based reference model.
module tb_pipe_stage_reg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, in_valid, stall, flush;
    logic [63:0] in_data;
    logic [7:0]  in_ctrl;

    logic        v3, v2;
    logic [63:0] d3, d2;
    logic [7:0]  c3, c2;
    logic [1:0]  o3, o2;
    logic [15:0] f3, f2;

    pipe_stage_reg #(.DATA_W(64), .CTRL_W(8), .DEPTH(3), .ZERO_DATA_ON_FLUSH(1)) u_d3 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ctrl(in_ctrl),
        .stall(stall), .flush(flush), .out_valid(v3), .out_data(d3), .out_ctrl(c3),
        .occupancy(o3), .flush_count(f3)
    );

    pipe_stage_reg #(.DATA_W(64), .CTRL_W(8), .DEPTH(2), .ZERO_DATA_ON_FLUSH(0)) u_d2 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ctrl(in_ctrl),
        .stall(stall), .flush(flush), .out_valid(v2), .out_data(d2), .out_ctrl(c2),
        .occupancy(o2), .flush_count(f2)
    );

    logic        act_v [2];
    logic [63:0] act_d [2];
    logic [7:0]  act_c [2];
    int unsigned act_o [2];
    logic [15:0] act_f [2];
    always_comb begin
        act_v[0] = v3; act_d[0] = d3; act_c[0] = c3; act_o[0] = int'(o3); act_f[0] = f3;
        act_v[1] = v2; act_d[1] = d2; act_c[1] = c2; act_o[1] = int'(o2); act_f[1] = f2;
    end

    // Reference: each instance is a queue of slots, newest at the front.
    typedef struct {
        logic        v;
        logic [63:0] d;
        logic [7:0]  c;
    } slot_t;

    slot_t       mq [2][$];
    int unsigned dep [2]  = '{3, 2};
    bit          zero [2] = '{1'b1, 1'b0};
    int unsigned mfc [2]  = '{0, 0};

    int checks   = 0;
    int failures = 0;

    function automatic int unsigned m_occ(int i);
        int unsigned n = 0;
        for (int k = 0; k < mq[i].size(); k++) n += mq[i][k].v ? 1 : 0;
        return n;
    endfunction

    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            if (!reset) begin
                slot_t z;
                z = '{v: 1'b0, d: 64'd0, c: 8'd0};
                mq[i].delete();
                for (int k = 0; k < int'(dep[i]); k++) mq[i].push_back(z);
                mfc[i] = 0;
            end else if (flush) begin
                for (int k = 0; k < int'(dep[i]); k++) begin
                    mq[i][k].v = 1'b0;
                    mq[i][k].c = 8'd0;
                    if (zero[i]) mq[i][k].d = 64'd0;
                end
                if (mfc[i] < 65535) mfc[i]++;
            end else if (!stall) begin
                slot_t s;
                s.v = in_valid;
                s.d = in_data;
                s.c = in_valid ? in_ctrl : 8'd0;
                mq[i].push_front(s);
                void'(mq[i].pop_back());
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive(logic v, logic [63:0] d, logic [7:0] c, logic s, logic f);
        in_valid = v; in_data = d; in_ctrl = c; stall = s; flush = f;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        drive(1'b1, 64'hDEAD, 8'hFF, 1'b0, 1'b0);
        cycle();
        cycle();
        for (int i = 0; i < 2; i++) begin
            checks += 5;
            if (act_v[i] !== 1'b0) begin
                failures++; $display("FAIL reset_valid[%0d] got %0b want 0", i, act_v[i]);
            end
            if (act_d[i] !== 64'd0) begin
                failures++; $display("FAIL reset_data[%0d] got %h want 0", i, act_d[i]);
            end
            if (act_c[i] !== 8'd0) begin
                failures++; $display("FAIL reset_ctrl[%0d] got %h want 0", i, act_c[i]);
            end
            if (act_o[i] != 0) begin
                failures++; $display("FAIL reset_occ[%0d] got %0d want 0", i, act_o[i]);
            end
            if (act_f[i] !== 16'd0) begin
                failures++; $display("FAIL reset_fcnt[%0d] got %0d want 0", i, act_f[i]);
            end
        end
        reset = 1'b1;
    endtask

    // DEPTH=3 instance: item n (captured at edge n) must appear at edge n+2.
    task automatic test_latency();
        for (int n = 1; n <= 6; n++) begin
            if (n <= 4) drive(1'b1, 64'(n), 8'(n), 1'b0, 1'b0);
            else        drive(1'b0, 64'd0, 8'd0, 1'b0, 1'b0);
            cycle();
            if (n >= 3) begin
                checks += 2;
                if (v3 !== 1'b1) begin
                    failures++; $display("FAIL lat_valid edge %0d got %0b want 1", n, v3);
                end
                if (d3 !== 64'(n - 2)) begin
                    failures++; $display("FAIL lat_data edge %0d got %0d want %0d", n, d3, n - 2);
                end
            end else begin
                checks++;
                if (v3 !== 1'b0) begin
                    failures++; $display("FAIL lat_early edge %0d got %0b want 0", n, v3);
                end
            end
            if (n == 3 || n == 4) begin
                checks++;
                if (o3 !== 2'd3) begin
                    failures++; $display("FAIL lat_occ edge %0d got %0d want 3", n, o3);
                end
            end
        end
    endtask

    // DEPTH=2 instance: get 6 onto the output, then stall while 7 is offered.
    task automatic test_stall();
        drive(1'b1, 64'd5, 8'h05, 1'b0, 1'b0); cycle();
        drive(1'b1, 64'd6, 8'h06, 1'b0, 1'b0); cycle();
        drive(1'b0, 64'd0, 8'h00, 1'b0, 1'b0); cycle();
        for (int n = 0; n < 2; n++) begin
            drive(1'b1, 64'd7, 8'h07, 1'b1, 1'b0);
            cycle();
            checks += 3;
            if (v2 !== 1'b1) begin
                failures++; $display("FAIL stall_valid cyc %0d got %0b want 1", n, v2);
            end
            if (d2 !== 64'd6) begin
                failures++; $display("FAIL stall_data cyc %0d got %0d want 6", n, d2);
            end
            if (c2 !== 8'h06) begin
                failures++; $display("FAIL stall_ctrl cyc %0d got %h want 06", n, c2);
            end
        end
        for (int n = 0; n < 2; n++) begin
            drive(1'b0, 64'd0, 8'h00, 1'b0, 1'b0);
            cycle();
            checks++;
            if (d2 === 64'd7 || v2 !== 1'b0) begin
                failures++; $display("FAIL stall_leak cyc %0d got v=%0b d=%0d want v=0 d!=7", n, v2, d2);
            end
        end
    endtask

    task automatic test_flush_stall();
        for (int n = 11; n <= 13; n++) begin
            drive(1'b1, 64'(n), 8'hA0, 1'b0, 1'b0);
            cycle();
        end
        drive(1'b1, 64'd99, 8'hFF, 1'b1, 1'b1);
        cycle();
        for (int i = 0; i < 2; i++) begin
            checks += 4;
            if (act_v[i] !== 1'b0) begin
                failures++; $display("FAIL fl_valid[%0d] got %0b want 0", i, act_v[i]);
            end
            if (act_c[i] !== 8'd0) begin
                failures++; $display("FAIL fl_ctrl[%0d] got %h want 0", i, act_c[i]);
            end
            if (act_o[i] != 0) begin
                failures++; $display("FAIL fl_occ[%0d] got %0d want 0", i, act_o[i]);
            end
            if (act_f[i] !== 16'd1) begin
                failures++; $display("FAIL fl_fcnt[%0d] got %0d want 1", i, act_f[i]);
            end
        end
        checks += 2;
        if (d3 !== 64'd0) begin
            failures++; $display("FAIL fl_data_zero got %0d want 0", d3);
        end
        if (d2 !== 64'd12) begin
            failures++; $display("FAIL fl_data_hold got %0d want 12", d2);
        end
        drive(1'b0, 64'd0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_bubble();
        drive(1'b0, 64'h1234, 8'hFF, 1'b0, 1'b0);
        cycle();
        for (int n = 2; n <= 3; n++) begin
            drive(1'b1, 64'h55, 8'h3C, 1'b0, 1'b0);
            cycle();
            if (n == 2) begin
                checks += 2;
                if (v2 !== 1'b0 || c2 !== 8'd0) begin
                    failures++; $display("FAIL bubble_d2 got v=%0b c=%h want v=0 c=00", v2, c2);
                end
                if (c3 !== 8'd0) begin
                    failures++; $display("FAIL bubble_d3_pre got c=%h want 00", c3);
                end
            end else begin
                checks += 2;
                if (v3 !== 1'b0 || c3 !== 8'd0) begin
                    failures++; $display("FAIL bubble_d3 got v=%0b c=%h want v=0 c=00", v3, c3);
                end
                if (v2 !== 1'b1 || c2 !== 8'h3C) begin
                    failures++; $display("FAIL bubble_d2_next got v=%0b c=%h want v=1 c=3c", v2, c2);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            reset = ($urandom_range(0, 49) != 0);
            drive($urandom_range(0, 1) == 1, {$urandom, $urandom}, 8'($urandom),
                  $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0);
            cycle();
            for (int i = 0; i < 2; i++) begin
                slot_t e;
                e = mq[i][dep[i] - 1];
                checks += 5;
                if (act_v[i] !== e.v) begin
                    failures++; $display("FAIL rnd_valid[%0d] cyc %0d got %0b want %0b", i, n, act_v[i], e.v);
                end
                if (act_d[i] !== e.d) begin
                    failures++; $display("FAIL rnd_data[%0d] cyc %0d got %h want %h", i, n, act_d[i], e.d);
                end
                if (act_c[i] !== e.c) begin
                    failures++; $display("FAIL rnd_ctrl[%0d] cyc %0d got %h want %h", i, n, act_c[i], e.c);
                end
                if (act_o[i] != m_occ(i)) begin
                    failures++; $display("FAIL rnd_occ[%0d] cyc %0d got %0d want %0d", i, n, act_o[i], m_occ(i));
                end
                if (act_f[i] !== 16'(mfc[i])) begin
                    failures++; $display("FAIL rnd_fcnt[%0d] cyc %0d got %0d want %0d", i, n, act_f[i], mfc[i]);
                end
            end
        end
        reset = 1'b1;
        drive(1'b0, 64'd0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_saturation();
        reset = 1'b0;
        cycle();
        reset = 1'b1;
        drive(1'b1, 64'd1, 8'h01, 1'b0, 1'b1);
        for (int n = 0; n < 65534; n++) cycle();
        checks += 2;
        if (f3 !== 16'hFFFE) begin
            failures++; $display("FAIL sat_pre_d3 got %h want fffe", f3);
        end
        if (f2 !== 16'hFFFE) begin
            failures++; $display("FAIL sat_pre_d2 got %h want fffe", f2);
        end
        for (int n = 0; n < 3; n++) begin
            drive(1'b1, 64'd1, 8'h01, n == 1, 1'b1);
            cycle();
            checks += 2;
            if (f3 !== 16'hFFFF) begin
                failures++; $display("FAIL sat_d3 flush %0d got %h want ffff", n, f3);
            end
            if (f2 !== 16'hFFFF) begin
                failures++; $display("FAIL sat_d2 flush %0d got %h want ffff", n, f2);
            end
        end
        drive(1'b1, 64'd1, 8'h01, 1'b0, 1'b0);
        cycle();
        checks++;
        if (f3 !== 16'hFFFF) begin
            failures++; $display("FAIL sat_hold got %h want ffff", f3);
        end
    endtask

    initial begin
        reset = 1'b0;
        drive(1'b0, 64'd0, 8'd0, 1'b0, 1'b0);
        test_reset();
        test_latency();
        test_stall();
        test_flush_stall();
        test_bubble();
        test_random();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
